siso: RTL and testbench
=======================

Name: siso

Overview:
- Parameterised serial-in, serial-out shift register: a delay line of DEPTH flip-flops, advanced only when shift_en is high.
- Used wherever a serial bit stream must be delayed by a fixed number of enabled clock cycles, e.g. bit-serial datapaths and serial link alignment.
- Single clock domain, synchronous active-high reset.

Parameters:
- DEPTH, 4, number of register stages (delay in enabled shifts); legal range DEPTH >= 1.
- INIT_VALUE, {DEPTH{1'b0}}, DEPTH-bit value loaded into the stages on reset; bit DEPTH-1 is the output stage.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
- shift_en  input  1  shift enable; register advances one stage per rising edge while high.
- serial_in  input  1  serial data in, captured into stage 0 on an enabled edge.
- serial_out  output  1  serial data out, driven directly from stage DEPTH-1 (registered, no combinational path from any input).

Behaviour:
- Internal state is stage[DEPTH-1:0]; stage 0 is the input end and stage DEPTH-1 is the output end.
- Reset: on a rising edge with rst=1, stage <= INIT_VALUE, so serial_out = INIT_VALUE[DEPTH-1] (0 by default) after that edge.
- rst has priority over shift_en. With rst and shift_en both high, the edge performs a reset only; serial_in is discarded.
- Shift: on a rising edge with rst=0 and shift_en=1:
  - stage[0] <= serial_in;
  - stage[i] <= stage[i-1] for i = 1..DEPTH-1;
  - the previous stage[DEPTH-1] value is dropped.
- Hold: on a rising edge with rst=0 and shift_en=0, all stages keep their value and serial_out is unchanged.
- Latency: a bit captured on enabled edge n appears on serial_out immediately after enabled edge n+DEPTH-1, i.e. DEPTH enabled edges counting the capture edge.
  - Disabled edges do not count; latency is in enabled shifts, not clock cycles.
- DEPTH=1: a single enabled flop; serial_out follows serial_in one enabled edge later.
- Order is preserved: the output sequence equals the input sequence delayed by DEPTH enabled shifts, with no reordering or inversion.
- Reset mid-stream: any in-flight bits are discarded; the stream restarts from INIT_VALUE contents.
- Before reset the state is undefined (X in simulation). No output reset value is guaranteed until the first reset edge.
- Inputs are sampled only at the rising edge. Benches must change serial_in/shift_en away from the rising edge (on the falling edge).

Test Plan:
- Reset: assert rst for one rising edge with shift_en=1, serial_in=1 -> serial_out=0 after that edge; all stages 0.
- Streaming, DEPTH=4: shift_en=1, feed 8'b10101010 LSB first (0,1,0,1,0,1,0,1) on successive edges.
  - serial_out is 0,0,0 after edges 1-3 (reset contents);
  - then 0,1,0,1,0,1,0,1 after edges 4-11.
- Second stream: feed 8'b11001100 LSB first (0,0,1,1,0,0,1,1) immediately after the first stream, then serial_in=0 for 10 cycles.
  - serial_out reproduces 0,0,1,1,0,0,1,1, delayed by 4 enabled edges;
  - then flushes to constant 0.
- Enable gating: load 1,0,1,1, drop shift_en for 5 cycles while toggling serial_in.
  - serial_out holds its value for all 5 cycles;
  - after re-enabling, the remaining stored bits emerge unchanged, with no corruption from the toggled inputs.
- Reset mid-operation: with stages holding 1111, assert rst together with shift_en=1 -> serial_out=0 on the next edge, and the prior 1s never appear.
- DEPTH=1 instance: alternate serial_in each enabled edge -> serial_out equals serial_in from the previous enabled edge.

Source files
------------

// File: rtl/siso.sv
// -----------------------------------------------------------------------------
// siso - parameterised serial-in, serial-out shift register.
//
// A delay line of DEPTH flip-flops that advances one stage on every rising
// edge of clk where shift_en is high. A bit captured on an enabled edge
// appears on serial_out DEPTH enabled edges later (counting the capture edge).
// Disabled edges hold every stage, so the delay is measured in enabled shifts,
// not clock cycles.
//
// Parameters:
//   DEPTH       number of register stages (>= 1)
//   INIT_VALUE  DEPTH-bit value loaded on reset; bit DEPTH-1 is the output stage
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset, priority over shift_en
//   shift_en    shift enable
//   serial_in   serial data in, captured into stage 0 on an enabled edge
//   serial_out  serial data out, driven directly from stage DEPTH-1
// -----------------------------------------------------------------------------
module siso #(
   parameter int unsigned          DEPTH      = 4,
   parameter logic [DEPTH-1:0]     INIT_VALUE = '0
) (
   input  logic clk,
   input  logic rst,
   input  logic shift_en,
   input  logic serial_in,
   output logic serial_out
);

   logic [DEPTH-1:0] stage;

   // Per-stage loop rather than a concatenation so DEPTH=1 needs no
   // special-cased slice: the loop body simply never runs.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage <= INIT_VALUE;
      end else if (shift_en) begin
         stage[0] <= serial_in;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign serial_out = stage[DEPTH-1];

endmodule

// File: tb/tb_siso.sv
// -----------------------------------------------------------------------------
// tb_siso - self-checking bench for siso.
//
// Three instances share the same stimulus: DEPTH=4 (default), DEPTH=1, and
// DEPTH=3 with a non-zero INIT_VALUE. The driver changes inputs on the falling
// edge and queues the hand-computed outputs expected after the next rising
// edge; a monitor pops one entry per rising edge and compares.
// Entry bit 0 = DEPTH=4 instance, bit 1 = DEPTH=1, bit 2 = DEPTH=3.
// -----------------------------------------------------------------------------
module tb_siso;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic shift_en = 1'b0;
   logic serial_in = 1'b0;
   logic out4, out1, out3;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [2:0] chk;
      logic [2:0] exp;
      string      name;
   } sb_entry_t;

   sb_entry_t sb[$];

   always #5 clk = ~clk;

   siso #(.DEPTH(4)) dut4 (
      .clk(clk), .rst(rst), .shift_en(shift_en),
      .serial_in(serial_in), .serial_out(out4)
   );

   siso #(.DEPTH(1)) dut1 (
      .clk(clk), .rst(rst), .shift_en(shift_en),
      .serial_in(serial_in), .serial_out(out1)
   );

   siso #(.DEPTH(3), .INIT_VALUE(3'b101)) dut3 (
      .clk(clk), .rst(rst), .shift_en(shift_en),
      .serial_in(serial_in), .serial_out(out3)
   );

   task automatic step(input logic r, input logic en, input logic d,
                       input logic [2:0] chk, input logic [2:0] exp,
                       input string nm);
      sb_entry_t e;
      @(negedge clk);
      rst       = r;
      shift_en  = en;
      serial_in = d;
      e.chk  = chk;
      e.exp  = exp;
      e.name = nm;
      sb.push_back(e);
   endtask

   // Monitor: one expectation per rising edge, sampled 1 time unit after it.
   initial begin
      sb_entry_t e;
      logic [2:0] act;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            act = {out3, out1, out4};
            for (int k = 0; k < 3; k++) begin
               if (e.chk[k]) begin
                  checks++;
                  if (act[k] !== e.exp[k]) begin
                     failures++;
                     $display("FAIL %s inst%0d: got %b expected %b (t=%0t)",
                              e.name, k, act[k], e.exp[k], $time);
                  end
               end
            end
         end
      end
   end

   // Streams: 0,1,0,1,0,1,0,1 then 0,0,1,1,0,0,1,1 then ten 0s.
   // DEPTH=4 output after edge k is the input of edge k-3 (0 before that).
   bit s_in [26] = '{0,1,0,1,0,1,0,1, 0,0,1,1,0,0,1,1, 0,0,0,0,0,0,0,0,0,0};
   bit s_e4 [26] = '{0,0,0,0,1,0,1,0, 1,0,1,0,0,1,1,0, 0,1,1,0,0,0,0,0,0,0};
   // DEPTH=3 INIT 101 around the first reset: 1, then 0, 1, 0.
   bit s_e3 [4]  = '{1,0,1,0};

   initial begin
      logic [2:0] chk;
      logic [2:0] exp;

      // Edge 1 is the reset edge (rst=1, shift_en=1, serial_in=1);
      // edges 2..26 carry the streams with DEPTH=4 expectations offset by one.
      step(1'b1, 1'b1, 1'b1, 3'b111, 3'b100, "reset");
      for (int i = 0; i < 25; i++) begin
         chk = {(i < 3) ? 1'b1 : 1'b0, 1'b1, 1'b1};
         exp = {(i < 3) ? logic'(s_e3[i+1]) : 1'b0, logic'(s_in[i]), logic'(s_e4[i])};
         step(1'b0, 1'b1, logic'(s_in[i]), chk, exp, "stream");
      end
      // Last stream entry (26th input, zero) and its DEPTH=4 output.
      step(1'b0, 1'b1, logic'(s_in[25]), 3'b011, {1'b0, logic'(s_in[25]), logic'(s_e4[25])}, "stream");

      // Enable gating: stages hold zeros; load 1,0,1,1.
      step(1'b0, 1'b1, 1'b1, 3'b011, 3'b010, "gate_load");
      step(1'b0, 1'b1, 1'b0, 3'b011, 3'b000, "gate_load");
      step(1'b0, 1'b1, 1'b1, 3'b011, 3'b010, "gate_load");
      step(1'b0, 1'b1, 1'b1, 3'b011, 3'b011, "gate_load");
      // Five disabled edges with a toggling input: all outputs hold.
      step(1'b0, 1'b0, 1'b0, 3'b011, 3'b011, "gate_hold");
      step(1'b0, 1'b0, 1'b1, 3'b011, 3'b011, "gate_hold");
      step(1'b0, 1'b0, 1'b0, 3'b011, 3'b011, "gate_hold");
      step(1'b0, 1'b0, 1'b1, 3'b011, 3'b011, "gate_hold");
      step(1'b0, 1'b0, 1'b0, 3'b011, 3'b011, "gate_hold");
      // Re-enable: remaining bits 0,1,1 drain, then the new 0.
      step(1'b0, 1'b1, 1'b0, 3'b011, 3'b000, "gate_drain");
      step(1'b0, 1'b1, 1'b0, 3'b011, 3'b001, "gate_drain");
      step(1'b0, 1'b1, 1'b0, 3'b011, 3'b001, "gate_drain");
      step(1'b0, 1'b1, 1'b0, 3'b011, 3'b000, "gate_drain");

      // Mid-stream reset: fill with 1111, then reset with shift_en=1.
      step(1'b0, 1'b1, 1'b1, 3'b011, 3'b010, "fill");
      step(1'b0, 1'b1, 1'b1, 3'b011, 3'b010, "fill");
      step(1'b0, 1'b1, 1'b1, 3'b011, 3'b010, "fill");
      step(1'b0, 1'b1, 1'b1, 3'b011, 3'b011, "fill");
      step(1'b1, 1'b1, 1'b1, 3'b111, 3'b100, "mid_reset");
      // The stale 1s must never surface; DEPTH=3 drains INIT 101 as 0,1,0.
      step(1'b0, 1'b1, 1'b0, 3'b111, 3'b000, "post_reset");
      step(1'b0, 1'b1, 1'b0, 3'b111, 3'b100, "post_reset");
      step(1'b0, 1'b1, 1'b0, 3'b111, 3'b000, "post_reset");
      step(1'b0, 1'b1, 1'b0, 3'b111, 3'b000, "post_reset");

      // DEPTH=1: output is the input of the previous enabled edge.
      step(1'b0, 1'b1, 1'b1, 3'b010, 3'b010, "depth1");
      step(1'b0, 1'b1, 1'b0, 3'b010, 3'b000, "depth1");
      step(1'b0, 1'b0, 1'b1, 3'b010, 3'b000, "depth1_hold");
      step(1'b0, 1'b1, 1'b1, 3'b010, 3'b010, "depth1");
      step(1'b0, 1'b1, 1'b0, 3'b010, 3'b000, "depth1");
      step(1'b0, 1'b1, 1'b1, 3'b010, 3'b010, "depth1");

      // Let the monitor drain the scoreboard, bounded in cycles.
      for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
